// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter_if
// Description : Master-side and slave-side naive_bus signals of the RAM port
//               arbiter. The arbiter uses the 'slave' modport. The requesters
//               and the RAM use the 'master' modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int AW        = 32,
  parameter int DW        = 32
);
  localparam int BW = DW / 8;

  // Requester side, one slice per master
  logic [N_MASTERS-1:0]      m_rd_req;
  logic [N_MASTERS*AW-1:0]   m_rd_addr;
  logic [N_MASTERS-1:0]      m_rd_gnt;
  logic [N_MASTERS*DW-1:0]   m_rd_data;
  logic [N_MASTERS-1:0]      m_rd_valid;
  logic [N_MASTERS-1:0]      m_wr_req;
  logic [N_MASTERS*AW-1:0]   m_wr_addr;
  logic [N_MASTERS*DW-1:0]   m_wr_data;
  logic [N_MASTERS*BW-1:0]   m_wr_be;
  logic [N_MASTERS-1:0]      m_wr_gnt;

  // Shared RAM slave side
  logic                      s_rd_req;
  logic [AW-1:0]             s_rd_addr;
  logic                      s_rd_gnt;
  logic [DW-1:0]             s_rd_data;
  logic                      s_wr_req;
  logic [AW-1:0]             s_wr_addr;
  logic [DW-1:0]             s_wr_data;
  logic [BW-1:0]             s_wr_be;
  logic                      s_wr_gnt;

  modport slave (
    input  m_rd_req, m_rd_addr, m_wr_req, m_wr_addr, m_wr_data, m_wr_be,
    output m_rd_gnt, m_rd_data, m_rd_valid, m_wr_gnt,
    output s_rd_req, s_rd_addr, s_wr_req, s_wr_addr, s_wr_data, s_wr_be,
    input  s_rd_gnt, s_rd_data, s_wr_gnt
  );

  modport master (
    output m_rd_req, m_rd_addr, m_wr_req, m_wr_addr, m_wr_data, m_wr_be,
    input  m_rd_gnt, m_rd_data, m_rd_valid, m_wr_gnt,
    input  s_rd_req, s_rd_addr, s_wr_req, s_wr_addr, s_wr_data, s_wr_be,
    output s_rd_gnt, s_rd_data, s_wr_gnt
  );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Shares one RAM slave port between N_MASTERS masters. The read
//               and write channels each use their own round-robin arbiter.
//               Read data (1-cycle latency) is routed back to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_port_arbiter_if.slave  bus
);
  localparam int BW = DW / 8;
  localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_owner_q, rd_owner_d;
  logic          rd_pend_q, rd_pend_d;

  logic          rd_any, wr_any;
  logic [PW-1:0] rd_win, wr_win;
  logic [AW-1:0] rd_addr_sel, wr_addr_sel;
  logic [DW-1:0] wr_data_sel;
  logic [BW-1:0] wr_be_sel;
  logic          raw_hazard;
  logic          rd_fire, wr_fire;

  // Returns {found, index} of the first requester at or above ptr, modulo N
  function automatic logic [PW:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                          input logic [PW-1:0]        ptr);
    int idx;
    rr_pick = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_MASTERS;
      if (req[PW'(idx)]) rr_pick = {1'b1, PW'(idx)};
    end
  endfunction

  always_comb begin
    {rd_any, rd_win} = rr_pick(bus.m_rd_req, rd_ptr_q);
    {wr_any, wr_win} = rr_pick(bus.m_wr_req, wr_ptr_q);

    rd_addr_sel = '0;
    wr_addr_sel = '0;
    wr_data_sel = '0;
    wr_be_sel   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (rd_win == PW'(i)) rd_addr_sel = bus.m_rd_addr[i*AW +: AW];
      if (wr_win == PW'(i)) begin
        wr_addr_sel = bus.m_wr_addr[i*AW +: AW];
        wr_data_sel = bus.m_wr_data[i*DW +: DW];
        wr_be_sel   = bus.m_wr_be[i*BW +: BW];
      end
    end

    // A read of the word being written this cycle waits one cycle so it sees the new data
    raw_hazard = rd_any && wr_any && (rd_addr_sel[AW-1:2] == wr_addr_sel[AW-1:2]);

    bus.s_rd_req  = rst_n && rd_any && !raw_hazard;
    bus.s_wr_req  = rst_n && wr_any;
    bus.s_rd_addr = bus.s_rd_req ? rd_addr_sel : '0;
    bus.s_wr_addr = bus.s_wr_req ? wr_addr_sel : '0;
    bus.s_wr_data = bus.s_wr_req ? wr_data_sel : '0;
    bus.s_wr_be   = bus.s_wr_req ? wr_be_sel   : '0;

    rd_fire = bus.s_rd_req && bus.s_rd_gnt;
    wr_fire = bus.s_wr_req && bus.s_wr_gnt;

    bus.m_rd_gnt   = '0;
    bus.m_wr_gnt   = '0;
    bus.m_rd_valid = '0;
    bus.m_rd_data  = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      bus.m_rd_gnt[i]   = rd_fire && (rd_win == PW'(i));
      bus.m_wr_gnt[i]   = wr_fire && (wr_win == PW'(i));
      bus.m_rd_valid[i] = rd_pend_q && (rd_owner_q == PW'(i));
      if (bus.m_rd_valid[i]) bus.m_rd_data[i*DW +: DW] = bus.s_rd_data;
    end

    rd_ptr_d   = rd_fire ? PW'((int'(rd_win) + 1) % N_MASTERS) : rd_ptr_q;
    wr_ptr_d   = wr_fire ? PW'((int'(wr_win) + 1) % N_MASTERS) : wr_ptr_q;
    rd_pend_d  = rd_fire;
    rd_owner_d = rd_fire ? rd_win : rd_owner_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_owner_q <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_owner_q <= rd_owner_d;
      rd_pend_q  <= rd_pend_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Scoreboard bench for ram_port_arbiter with a behavioural
//               round-robin/RAM reference model and an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.N_MASTERS(N), .AW(AW), .DW(DW)) bus ();

  ram_port_arbiter #(.N_MASTERS(N), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RAM slave: 1-cycle read latency, byte-enabled writes
  logic [DW-1:0] ram [MW];
  logic [DW-1:0] rdata_q = '0;
  assign bus.s_rd_data = rdata_q;
  always @(posedge clk) begin
    if (bus.s_wr_req && bus.s_wr_gnt)
      for (int b = 0; b < BW; b++)
        if (bus.s_wr_be[b]) ram[bus.s_wr_addr[7:2]][b*8 +: 8] <= bus.s_wr_data[b*8 +: 8];
    if (bus.s_rd_req && bus.s_rd_gnt) rdata_q <= ram[bus.s_rd_addr[7:2]];
  end

  // Reference model: memory image, two rotating priority pointers, return queue
  typedef struct { int owner; logic [DW-1:0] data; int due; } ret_t;
  ret_t          q[$];
  logic [DW-1:0] ref_mem [MW];
  int            rptr = 0, wptr = 0;

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  int            rw, ww;
  logic          hz, srq;
  logic [N-1:0]  erg, ewg;
  logic [AW-1:0] ra, wa;
  logic [DW-1:0] wd;
  logic [BW-1:0] wb;

  always @(negedge clk) begin : model
    if (!rst_n) begin
      q.delete();
      rptr = 0;
      wptr = 0;
      chk("rst_rd_gnt", 64'(bus.m_rd_gnt), 0);
      chk("rst_wr_gnt", 64'(bus.m_wr_gnt), 0);
      chk("rst_s_req", {62'd0, bus.s_rd_req, bus.s_wr_req}, 0);
    end else begin
      rw = pick(bus.m_rd_req, rptr);
      ww = pick(bus.m_wr_req, wptr);
      ra = (rw >= 0) ? bus.m_rd_addr[rw*AW +: AW] : '0;
      wa = (ww >= 0) ? bus.m_wr_addr[ww*AW +: AW] : '0;
      wd = (ww >= 0) ? bus.m_wr_data[ww*DW +: DW] : '0;
      wb = (ww >= 0) ? bus.m_wr_be[ww*BW +: BW]   : '0;
      hz  = (rw >= 0) && (ww >= 0) && (ra[AW-1:2] == wa[AW-1:2]);
      srq = (rw >= 0) && !hz;
      erg = '0;
      ewg = '0;
      if (srq && bus.s_rd_gnt) erg[rw] = 1'b1;
      if ((ww >= 0) && bus.s_wr_gnt) ewg[ww] = 1'b1;
      chk("s_rd_req", 64'(bus.s_rd_req), 64'(srq));
      chk("s_wr_req", 64'(bus.s_wr_req), 64'(ww >= 0));
      chk("m_rd_gnt", 64'(bus.m_rd_gnt), 64'(erg));
      chk("m_wr_gnt", 64'(bus.m_wr_gnt), 64'(ewg));
      if (srq) chk("s_rd_addr", 64'(bus.s_rd_addr), 64'(ra));
      if (ww >= 0) begin
        chk("s_wr_addr", 64'(bus.s_wr_addr), 64'(wa));
        chk("s_wr_data", 64'(bus.s_wr_data), 64'(wd));
        chk("s_wr_be",   64'(bus.s_wr_be),   64'(wb));
      end
      if (erg != '0) begin
        q.push_back('{owner: rw, data: ref_mem[ra[7:2]], due: cyc + 1});
        rptr = (rw + 1) % N;
      end
      if (ewg != '0) begin
        for (int b = 0; b < BW; b++)
          if (wb[b]) ref_mem[wa[7:2]][b*8 +: 8] = wd[b*8 +: 8];
        wptr = (ww + 1) % N;
      end
    end
  end

  ret_t          e;
  logic [N*DW-1:0] ed;

  always @(negedge clk) begin : monitor
    if (!rst_n) begin
      chk("rst_rd_valid", 64'(bus.m_rd_valid), 0);
      chk("rst_rd_data",  64'(bus.m_rd_data),  0);
    end else if (bus.m_rd_valid != '0) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 64'(bus.m_rd_valid), 0);
      end else begin
        e  = q.pop_front();
        ed = '0;
        ed[e.owner*DW +: DW] = e.data;
        chk("ret_valid", 64'(bus.m_rd_valid), 64'(1) << e.owner);
        chk("ret_cycle", 64'(cyc), 64'(e.due));
        chk("ret_data",  64'(bus.m_rd_data), 64'(ed));
      end
    end else begin
      chk("idle_rd_data", 64'(bus.m_rd_data), 0);
      if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_valid", 64'(bus.m_rd_valid), 64'(1) << q[0].owner);
        void'(q.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
  endtask

  // Issue one read and/or one write, each held until granted; entered and left at posedge+1
  task automatic run_ops(input bit rd_en, input int rm, input logic [AW-1:0] raddr,
                         input bit wr_en, input int wm, input logic [AW-1:0] waddr,
                         input logic [DW-1:0] wdata, input logic [BW-1:0] wbe);
    bit rp = rd_en, wp = wr_en, rg, wg;
    int guard = 0;
    if (rd_en) begin
      bus.m_rd_req[rm] = 1'b1;
      bus.m_rd_addr[rm*AW +: AW] = raddr;
    end
    if (wr_en) begin
      bus.m_wr_req[wm] = 1'b1;
      bus.m_wr_addr[wm*AW +: AW] = waddr;
      bus.m_wr_data[wm*DW +: DW] = wdata;
      bus.m_wr_be[wm*BW +: BW]   = wbe;
    end
    while ((rp || wp) && guard < 50) begin
      @(negedge clk);
      rg = rp && bus.m_rd_gnt[rm];
      wg = wp && bus.m_wr_gnt[wm];
      @(posedge clk);
      #1;
      if (rg) begin bus.m_rd_req[rm] = 1'b0; rp = 1'b0; end
      if (wg) begin bus.m_wr_req[wm] = 1'b0; wp = 1'b0; end
      guard++;
    end
    chk("op_timeout", {62'd0, rp, wp}, 0);
  endtask

  logic [N-1:0] gr, gw;

  initial begin
    for (int i = 0; i < MW; i++) begin
      ram[i]     = 32'hA5A5_0000 | DW'(i);
      ref_mem[i] = 32'hA5A5_0000 | DW'(i);
    end
    ram[4]     = 32'hA5A5_0001;
    ref_mem[4] = 32'hA5A5_0001;
    bus.m_rd_req = '0; bus.m_rd_addr = '0;
    bus.m_wr_req = '0; bus.m_wr_addr = '0; bus.m_wr_data = '0; bus.m_wr_be = '0;
    bus.s_rd_gnt = 1'b1; bus.s_wr_gnt = 1'b1;
    do_reset();

    // Single read of RAM[4]
    run_ops(1, 0, 32'h10, 0, 0, '0, '0, '0);
    wait_cyc(2);

    // Contention right after reset: M0,M1,M0,M1
    do_reset();
    bus.m_rd_req = 2'b11;
    bus.m_rd_addr = {32'h0000_0008, 32'h0000_000C};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("contention_gnt", 64'(bus.m_rd_gnt), (i % 2 == 0) ? 64'd1 : 64'd2);
    end
    @(posedge clk); #1;
    bus.m_rd_req = '0;
    wait_cyc(2);

    // Parallel channels, then read back the partial write
    run_ops(1, 1, 32'h30, 1, 0, 32'h20, 32'hDEAD_BEEF, 4'b0011);
    run_ops(1, 0, 32'h20, 0, 0, '0, '0, '0);
    wait_cyc(2);

    // RAW hazard: read of the word being written must wait and see the new data
    run_ops(1, 1, 32'h40, 1, 0, 32'h40, 32'h1234_5678, 4'b1111);
    wait_cyc(2);

    // Slave stall
    bus.s_rd_gnt = 1'b0;
    bus.m_rd_req[1] = 1'b1;
    bus.m_rd_addr[AW +: AW] = 32'h34;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_no_gnt", 64'(bus.m_rd_gnt), 0);
      @(posedge clk); #1;
    end
    bus.s_rd_gnt = 1'b1;
    @(negedge clk);
    chk("stall_release_gnt", 64'(bus.m_rd_gnt), 64'd2);
    @(posedge clk); #1;
    bus.m_rd_req = '0;
    wait_cyc(2);

    // Reset with a read return pending
    bus.m_rd_req[0] = 1'b1;
    bus.m_rd_addr[0 +: AW] = 32'h10;
    @(negedge clk);
    chk("mid_reset_gnt", 64'(bus.m_rd_gnt), 64'd1);
    #2;
    rst_n = 1'b0;
    bus.m_rd_req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_ops(1, 1, 32'h50, 0, 0, '0, '0, '0);
    wait_cyc(2);

    // Randomized traffic over a small shared word range to provoke hazards
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      gr = bus.m_rd_gnt;
      gw = bus.m_wr_gnt;
      @(posedge clk); #1;
      for (int m = 0; m < N; m++) begin
        if (gr[m] || (bus.m_rd_req[m] && $urandom_range(0, 15) == 0)) begin
          bus.m_rd_req[m] = 1'b0;
        end else if (!bus.m_rd_req[m] && $urandom_range(0, 2) == 0) begin
          bus.m_rd_req[m] = 1'b1;
          bus.m_rd_addr[m*AW +: AW] = AW'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        end
        if (gw[m] || (bus.m_wr_req[m] && $urandom_range(0, 15) == 0)) begin
          bus.m_wr_req[m] = 1'b0;
        end else if (!bus.m_wr_req[m] && $urandom_range(0, 2) == 0) begin
          bus.m_wr_req[m] = 1'b1;
          bus.m_wr_addr[m*AW +: AW] = AW'($urandom_range(0, 15) * 4);
          bus.m_wr_data[m*DW +: DW] = DW'($urandom);
          bus.m_wr_be[m*BW +: BW]   = BW'($urandom);
        end
      end
      bus.s_rd_gnt = ($urandom_range(0, 3) != 0);
      bus.s_wr_gnt = ($urandom_range(0, 3) != 0);
    end
    bus.m_rd_req = '0;
    bus.m_wr_req = '0;
    bus.s_rd_gnt = 1'b1;
    bus.s_wr_gnt = 1'b1;
    wait_cyc(4);
    chk("queue_drained", 64'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
